// File: rtl/bias_ctrl_pkg.sv
// Shared definitions for the bias cell startup controller: FSM encoding,
// trim code widths and trim reset values.
package bias_ctrl_pkg;

  localparam int TRIM_IBIAS_W = 5;
  localparam int TRIM_VBIAS_W = 4;

  localparam logic [TRIM_IBIAS_W-1:0] TRIM_IBIAS_DEF = 5'd16;
  localparam logic [TRIM_VBIAS_W-1:0] TRIM_VBIAS_DEF = 4'd8;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_STARTUP    = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_WAIT_VALID = 3'd3,
    ST_READY      = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  // States in which the bandgap is still coming up and trim must not move.
  function automatic logic is_settling(input state_t s);
    return (s == ST_STARTUP) || (s == ST_SETTLE) || (s == ST_WAIT_VALID);
  endfunction

endpackage

// File: rtl/bias_valid_sync.sv
// Two-flop synchronizer bringing the bias cell's valid flag into the core clock.
module bias_valid_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  // Capture the asynchronous level, then re-register it to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/bias_startup_ctrl.sv
// Sequencer for the 1.8 V I/O bias cell: enables, startup pulse, settle wait,
// bounded wait for bandgap valid with retries, and trim application that is
// held off while the bias is settling. All cell-facing outputs are registered.
module bias_startup_ctrl
  import bias_ctrl_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [TRIM_IBIAS_W-1:0] TRIM_IBIAS_RST = TRIM_IBIAS_DEF,
  parameter logic [TRIM_VBIAS_W-1:0] TRIM_VBIAS_RST = TRIM_VBIAS_DEF
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic                    REQ_IBIAS_I,
  input  logic                    REQ_VBIAS_I,
  input  logic                    TRIM_LOAD_I,
  input  logic [TRIM_IBIAS_W-1:0] TRIM_IBIAS_I,
  input  logic [TRIM_VBIAS_W-1:0] TRIM_VBIAS_I,
  input  logic                    BG_VALID_I,
  output logic                    EN_IBIAS_O,
  output logic                    EN_VBIAS_O,
  output logic                    BG_STARTUP_O,
  output logic [TRIM_IBIAS_W-1:0] TRIM_IBIAS_O,
  output logic [TRIM_VBIAS_W-1:0] TRIM_VBIAS_O,
  output logic                    READY_O,
  output logic                    FAULT_O,
  output logic                    TRIM_PEND_O,
  output logic [2:0]              STATE_O
);

  localparam int unsigned MAX_A  = (STARTUP_CYCLES > SETTLE_CYCLES) ? STARTUP_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int          CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] LD_STARTUP = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry, retry_nxt;
  logic             request;
  logic             valid_s;

  logic [TRIM_IBIAS_W-1:0] shadow_ibias;
  logic [TRIM_VBIAS_W-1:0] shadow_vbias;

  bias_valid_sync u_valid_sync (
    .clk   (CLK_I),
    .rst_n (RSTN_I),
    .d     (BG_VALID_I),
    .q     (valid_s)
  );

  assign request = REQ_IBIAS_I | REQ_VBIAS_I;
  assign STATE_O = state;

  // Next-state logic; request removal overrides every other transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    retry_nxt = retry;
    if (!request) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          state_nxt = ST_STARTUP;
          cnt_nxt   = LD_STARTUP;
          retry_nxt = '0;
        end
        ST_STARTUP: begin
          if (cnt == '0) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = LD_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state_nxt = ST_WAIT_VALID;
            cnt_nxt   = LD_TIMEOUT;
          end
        end
        ST_WAIT_VALID: begin
          // Valid on the final timeout cycle still counts as success.
          if (valid_s) begin
            state_nxt = ST_READY;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            if (retry < RETRY_MAX) begin
              state_nxt = ST_STARTUP;
              cnt_nxt   = LD_STARTUP;
              retry_nxt = retry + 4'd1;
            end else begin
              state_nxt = ST_FAULT;
              cnt_nxt   = '0;
            end
          end
        end
        ST_READY: begin
          if (!valid_s) state_nxt = ST_FAULT;
        end
        ST_FAULT: begin
          state_nxt = ST_FAULT;
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      endcase
    end
  end

  // State, counters and cell control outputs, registered from the next state.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state        <= ST_OFF;
      cnt          <= '0;
      retry        <= '0;
      EN_IBIAS_O   <= 1'b0;
      EN_VBIAS_O   <= 1'b0;
      BG_STARTUP_O <= 1'b0;
      READY_O      <= 1'b0;
      FAULT_O      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry        <= retry_nxt;
      EN_IBIAS_O   <= (state_nxt != ST_OFF) && REQ_IBIAS_I;
      EN_VBIAS_O   <= (state_nxt != ST_OFF) && REQ_VBIAS_I;
      BG_STARTUP_O <= (state_nxt == ST_STARTUP);
      READY_O      <= (state_nxt == ST_READY);
      FAULT_O      <= (state_nxt == ST_FAULT);
    end
  end

  // Trim shadow and outputs: loads go straight through in quiet states and
  // are parked while settling, then released when the sequence leaves settling.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      shadow_ibias <= TRIM_IBIAS_RST;
      shadow_vbias <= TRIM_VBIAS_RST;
      TRIM_IBIAS_O <= TRIM_IBIAS_RST;
      TRIM_VBIAS_O <= TRIM_VBIAS_RST;
      TRIM_PEND_O  <= 1'b0;
    end else begin
      if (TRIM_LOAD_I) begin
        shadow_ibias <= TRIM_IBIAS_I;
        shadow_vbias <= TRIM_VBIAS_I;
      end
      if (is_settling(state)) begin
        if (!is_settling(state_nxt)) begin
          TRIM_IBIAS_O <= TRIM_LOAD_I ? TRIM_IBIAS_I : shadow_ibias;
          TRIM_VBIAS_O <= TRIM_LOAD_I ? TRIM_VBIAS_I : shadow_vbias;
          TRIM_PEND_O  <= 1'b0;
        end else if (TRIM_LOAD_I) begin
          TRIM_PEND_O  <= 1'b1;
        end
      end else if (TRIM_LOAD_I) begin
        TRIM_IBIAS_O <= TRIM_IBIAS_I;
        TRIM_VBIAS_O <= TRIM_VBIAS_I;
      end
    end
  end

endmodule

// File: tb/tb_bias_startup_ctrl.sv
// Directed bench for bias_startup_ctrl with short sequencing parameters.
module tb_bias_startup_ctrl;

  logic       clk;
  logic       rstn;
  logic       req_ibias, req_vbias, trim_load, bg_valid;
  logic [4:0] trim_ibias_in;
  logic [3:0] trim_vbias_in;
  logic       en_ibias, en_vbias, bg_startup, ready, fault, trim_pend;
  logic [4:0] trim_ibias;
  logic [3:0] trim_vbias;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  bias_startup_ctrl #(
    .STARTUP_CYCLES (4),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (2),
    .TRIM_IBIAS_RST (5'd16),
    .TRIM_VBIAS_RST (4'd8)
  ) dut (
    .CLK_I        (clk),
    .RSTN_I       (rstn),
    .REQ_IBIAS_I  (req_ibias),
    .REQ_VBIAS_I  (req_vbias),
    .TRIM_LOAD_I  (trim_load),
    .TRIM_IBIAS_I (trim_ibias_in),
    .TRIM_VBIAS_I (trim_vbias_in),
    .BG_VALID_I   (bg_valid),
    .EN_IBIAS_O   (en_ibias),
    .EN_VBIAS_O   (en_vbias),
    .BG_STARTUP_O (bg_startup),
    .TRIM_IBIAS_O (trim_ibias),
    .TRIM_VBIAS_O (trim_vbias),
    .READY_O      (ready),
    .FAULT_O      (fault),
    .TRIM_PEND_O  (trim_pend),
    .STATE_O      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Width of the current startup pulse, counted from a cycle where it is high.
  task automatic pulse_width(output int w);
    w = bg_startup ? 1 : 0;
    while (bg_startup && w < 50) begin
      tick();
      if (bg_startup) w++;
    end
  endtask

  // Cycles from the end of a pulse until the next pulse or fault.
  task automatic gap_len(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bg_startup && !fault && n < 100);
  endtask

  task automatic load_trim(input logic [4:0] ib, input logic [3:0] vb);
    trim_ibias_in = ib;
    trim_vbias_in = vb;
    trim_load     = 1'b1;
    tick();
    trim_load     = 1'b0;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_en_i"},  en_ibias,   0);
    chk({tag, "_en_v"},  en_vbias,   0);
    chk({tag, "_bg"},    bg_startup, 0);
    chk({tag, "_ready"}, ready,      0);
    chk({tag, "_fault"}, fault,      0);
    chk({tag, "_state"}, state,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g;
    rstn = 1'b0; req_ibias = 0; req_vbias = 0; trim_load = 0; bg_valid = 0;
    trim_ibias_in = '0; trim_vbias_in = '0;
    repeat (3) tick();
    chk_off("rst");
    chk("rst_pend", trim_pend, 0);
    chk("rst_trim_i", trim_ibias, 16);
    chk("rst_trim_v", trim_vbias, 8);
    rstn = 1'b1;
    tick();

    // Trim load in OFF applies on the next edge.
    load_trim(5'd3, 4'd12);
    chk("off_trim_i", trim_ibias, 3);
    chk("off_trim_v", trim_vbias, 12);
    chk("off_pend", trim_pend, 0);
    load_trim(5'd16, 4'd8);
    chk("off_trim_i_back", trim_ibias, 16);

    // Nominal: current bias only, valid two cycles into WAIT_VALID.
    req_ibias = 1;
    tick();
    chk("nom_en_i", en_ibias, 1);
    chk("nom_en_v", en_vbias, 0);
    chk("nom_state_su", state, 1);
    pulse_width(w);
    chk("nom_pulse", w, 4);
    chk("nom_state_settle", state, 2);
    repeat (8) tick();
    chk("nom_state_wait", state, 3);
    repeat (2) tick();
    bg_valid = 1;
    repeat (2) tick();
    chk("nom_ready_early", ready, 0);
    tick();
    chk("nom_ready", ready, 1);
    chk("nom_state_ready", state, 4);
    chk("nom_fault", fault, 0);
    chk("nom_en_v_ready", en_vbias, 0);

    // Valid loss while ready.
    bg_valid = 0;
    repeat (2) tick();
    chk("loss_fault_early", fault, 0);
    tick();
    chk("loss_fault", fault, 1);
    chk("loss_ready", ready, 0);
    chk("loss_state", state, 5);
    req_ibias = 0;
    tick();
    chk_off("loss_off");

    // Timeout and retry: valid never comes.
    req_vbias = 1;
    tick();
    for (int a = 0; a < 3; a++) begin
      pulse_width(w);
      chk($sformatf("to_pulse%0d", a), w, 4);
      gap_len(g);
      chk($sformatf("to_gap%0d", a), g, 24);
    end
    chk("to_fault", fault, 1);
    chk("to_state", state, 5);
    chk("to_bg", bg_startup, 0);
    chk("to_en_v", en_vbias, 1);
    req_vbias = 0;
    tick();
    chk_off("to_off");

    // Late recovery during the second attempt.
    req_ibias = 1;
    tick();
    pulse_width(w);
    gap_len(g);
    chk("late_gap", g, 24);
    chk("late_state_su2", state, 1);
    pulse_width(w);
    chk("late_pulse2", w, 4);
    repeat (8) tick();
    chk("late_state_wait", state, 3);
    bg_valid = 1;
    repeat (3) tick();
    chk("late_ready", ready, 1);
    chk("late_fault", fault, 0);
    req_ibias = 0; bg_valid = 0;
    tick();
    chk_off("late_off");

    // Trim deferral while settling.
    req_ibias = 1;
    tick();
    pulse_width(w);
    chk("defer_state_settle", state, 2);
    load_trim(5'd3, 4'd12);
    chk("defer_pend", trim_pend, 1);
    chk("defer_hold_i", trim_ibias, 16);
    chk("defer_hold_v", trim_vbias, 8);
    bg_valid = 1;
    repeat (7) tick();
    chk("defer_state_wait", state, 3);
    chk("defer_hold_i2", trim_ibias, 16);
    tick();
    chk("defer_ready", ready, 1);
    chk("defer_trim_i", trim_ibias, 3);
    chk("defer_trim_v", trim_vbias, 12);
    chk("defer_pend_clr", trim_pend, 0);
    req_ibias = 0; bg_valid = 0;
    tick();

    // Asynchronous reset in the middle of a startup pulse.
    req_ibias = 1;
    repeat (2) tick();
    chk("ar_bg_before", bg_startup, 1);
    #2 rstn = 1'b0;
    #1;
    chk_off("ar");
    chk("ar_trim_i", trim_ibias, 16);
    chk("ar_trim_v", trim_vbias, 8);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("ar_restart_state", state, 1);
    pulse_width(w);
    chk("ar_restart_pulse", w, 4);
    req_ibias = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
